// File: rtl/qbert_pkg.sv
// Shared colours, map state encoding and cube indexing for the Q*bert pyramid renderer.
`default_nettype none

package qbert_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    FLASH = 2'd2,
    DONE  = 2'd3
  } map_state_e;

  localparam rgb_t C_BLACK = '{r: 8'd0,   g: 8'd0,   b: 8'd0};
  localparam rgb_t C_QBERT = '{r: 8'd216, g: 8'd95,  b: 8'd2};
  localparam rgb_t C_LEFT  = '{r: 8'd86,  g: 8'd169, b: 8'd152};
  localparam rgb_t C_RIGHT = '{r: 8'd49,  g: 8'd70,  b: 8'd70};
  localparam rgb_t C_TOP0  = '{r: 8'd86,  g: 8'd70,  b: 8'd239};
  localparam rgb_t C_TOP1  = '{r: 8'd222, g: 8'd222, b: 8'd0};
  localparam rgb_t C_TOP2  = '{r: 8'd239, g: 8'd86,  b: 8'd70};

  // Linear cube number: ranks are packed apex-first, left to right.
  function automatic int idx(input int r, input int p);
    return (r * (r + 1)) / 2 + p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/qbert_cube_face.sv
// Combinational face classifier for one cube anchored at (x_off, y_off).
`default_nettype none

module qbert_cube_face
  import qbert_pkg::*;
#(
  parameter logic [10:0] XLENGTH    = 11'd55,
  parameter logic [10:0] XDIAG_DEMI = 11'd30,
  parameter logic [9:0]  YDIAG_DEMI = 10'd50
) (
  input  logic [10:0] x_cnt_i,
  input  logic [9:0]  y_cnt_i,
  input  logic [10:0] x_off_i,
  input  logic [9:0]  y_off_i,
  output logic        left_o,
  output logic        right_o,
  output logic        top_o
);

  localparam logic signed [23:0] XD      = $signed({13'd0, XDIAG_DEMI});
  localparam logic signed [23:0] YD      = $signed({14'd0, YDIAG_DEMI});
  localparam logic signed [23:0] XL      = $signed({13'd0, XLENGTH});
  localparam logic signed [23:0] NEG_XLY = -(XL * YD);
  localparam logic signed [23:0] XDYD    = XD * YD;

  logic signed [23:0] dx_w, dy_w, dym_w, adx_w, ady_w, sl_w, sr_w;

  assign dx_w  = $signed({13'd0, x_cnt_i}) - $signed({13'd0, x_off_i});
  assign dy_w  = $signed({14'd0, y_cnt_i}) - $signed({14'd0, y_off_i});
  assign dym_w = dy_w - YD;
  assign adx_w = dx_w[23]  ? -dx_w  : dx_w;
  assign ady_w = dym_w[23] ? -dym_w : dym_w;

  // Side faces hang XLENGTH below the two lower edges of the top rhombus,
  // scaled by YD so the edge slope stays in integers.
  assign sl_w = YD * dx_w + XD * dy_w;
  assign sr_w = YD * dx_w + XD * (YD + YD - dy_w);

  assign left_o  = !dy_w[23] && (dy_w < YD) && sl_w[23] && (sl_w >= NEG_XLY);
  assign right_o = (dy_w >= YD) && (dy_w <= YD + YD) && sr_w[23] && (sr_w >= NEG_XLY);
  assign top_o   = (adx_w * YD + ady_w * XD) <= XDYD;

endmodule

`default_nettype wire

// File: rtl/qbert_pyramid_map.sv
// Q*bert pyramid renderer: 3-stage face/colour pipeline plus per-cube top state and level FSM.
`default_nettype none

module qbert_pyramid_map
  import qbert_pkg::*;
#(
  parameter int          N_RANKS      = 4,
  parameter logic [10:0] XLENGTH      = 11'd55,
  parameter logic [10:0] XDIAG_DEMI   = 11'd30,
  parameter logic [9:0]  YDIAG_DEMI   = 10'd50,
  parameter logic [10:0] APEX_X       = 11'd600,
  parameter logic [9:0]  APEX_Y       = 10'd90,
  parameter int          TOP_STATES   = 2,
  parameter int          FLASH_FRAMES = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [10:0] x_cnt_i,
  input  logic [9:0]  y_cnt_i,
  input  logic        qbert_pix_i,
  input  logic        level_start_i,
  input  logic        land_valid_i,
  output logic        land_ready_o,
  input  logic [2:0]  land_rank_i,
  input  logic [2:0]  land_pos_i,
  output logic [5:0]  cubes_done_o,
  output logic        score_pulse_o,
  output logic        level_clear_o,
  output logic [7:0]  red_o,
  output logic [7:0]  green_o,
  output logic [7:0]  blue_o
);

  localparam int N_CUBES = N_RANKS * (N_RANKS + 1) / 2;
  localparam int SW      = $clog2(TOP_STATES);
  localparam int IW      = $clog2(N_CUBES);
  localparam int FW_RAW  = $clog2(FLASH_FRAMES + 1);
  localparam int FW      = (FW_RAW < 4) ? 4 : FW_RAW;
  localparam logic [SW-1:0] TARGET = SW'(TOP_STATES - 1);

  map_state_e        state_q, state_d;
  logic [SW-1:0]     cube_q [N_CUBES];
  logic [SW-1:0]     cube_d [N_CUBES];
  logic [5:0]        done_q, done_d;
  logic [FW-1:0]     frame_q, frame_d;
  logic              pulse_q, pulse_d;

  logic [N_CUBES-1:0] left_w, right_w, top_w;
  logic [N_CUBES-1:0] face_l_q, face_r_q, face_t_q;
  logic               qbert_s1_q, qbert_s2_q;
  logic               left_s2_q, right_s2_q, top_s2_q;
  logic [SW-1:0]      top_st_s2_q, top_st_w;
  rgb_t               rgb_q, colour_d;

  logic               frame_tick_w, land_ok_w;
  logic [IW-1:0]      land_idx_w;

  for (genvar r = 0; r < N_RANKS; r++) begin : g_rank
    for (genvar p = 0; p <= r; p++) begin : g_pos
      localparam logic [10:0] XOFF =
        11'(int'(APEX_X) - r * (int'(XLENGTH) + int'(XDIAG_DEMI) + 1));
      localparam logic [9:0] YOFF =
        10'(int'(APEX_Y) + r * int'(YDIAG_DEMI) + p * (2 * int'(YDIAG_DEMI) + 1));
      qbert_cube_face #(
        .XLENGTH   (XLENGTH),
        .XDIAG_DEMI(XDIAG_DEMI),
        .YDIAG_DEMI(YDIAG_DEMI)
      ) u_face (
        .x_cnt_i(x_cnt_i),
        .y_cnt_i(y_cnt_i),
        .x_off_i(XOFF),
        .y_off_i(YOFF),
        .left_o (left_w[idx(r, p)]),
        .right_o(right_w[idx(r, p)]),
        .top_o  (top_w[idx(r, p)])
      );
    end
  end

  function automatic rgb_t top_colour(input logic [SW-1:0] s);
    rgb_t c;
    if (s == '0)                              c = C_TOP0;
    else if (s == TARGET && TOP_STATES == 3)  c = C_TOP2;
    else                                      c = C_TOP1;
    return c;
  endfunction

  assign frame_tick_w = (x_cnt_i == 11'd0) && (y_cnt_i == 10'd0);
  assign land_ok_w    = (int'(land_rank_i) < N_RANKS) && (land_pos_i <= land_rank_i);
  assign land_idx_w   = IW'(idx(int'(land_rank_i), int'(land_pos_i)));

  always_comb begin
    state_d = state_q;
    cube_d  = cube_q;
    done_d  = done_q;
    frame_d = frame_q;
    pulse_d = 1'b0;
    unique case (state_q)
      IDLE: ;
      PLAY: begin
        // land_ready is high throughout PLAY, so land_valid alone is a transfer.
        if (land_valid_i && land_ok_w && cube_q[land_idx_w] != TARGET) begin
          cube_d[land_idx_w] = cube_q[land_idx_w] + SW'(1);
          pulse_d            = 1'b1;
          if (cube_q[land_idx_w] + SW'(1) == TARGET) done_d = done_q + 6'd1;
        end
        if (done_q == 6'(N_CUBES)) state_d = FLASH;
      end
      FLASH: begin
        if (frame_tick_w) begin
          if (frame_q == FW'(FLASH_FRAMES - 1)) state_d = DONE;
          else                                  frame_d = frame_q + FW'(1);
        end
      end
      DONE: ;
    endcase
    if (level_start_i) begin
      state_d = PLAY;
      for (int i = 0; i < N_CUBES; i++) cube_d[i] = '0;
      done_d  = '0;
      frame_d = '0;
      pulse_d = 1'b0;
    end
  end

  always_comb begin
    top_st_w = '0;
    for (int i = 0; i < N_CUBES; i++) begin
      if (face_t_q[i]) top_st_w = top_st_w | cube_q[i];
    end
  end

  always_comb begin
    colour_d = C_BLACK;
    if (qbert_s2_q)      colour_d = C_QBERT;
    else if (left_s2_q)  colour_d = C_LEFT;
    else if (right_s2_q) colour_d = C_RIGHT;
    else if (top_s2_q) begin
      if (state_q == FLASH) colour_d = frame_q[3] ? C_TOP0 : top_colour(TARGET);
      else                  colour_d = top_colour(top_st_s2_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      done_q  <= '0;
      frame_q <= '0;
      pulse_q <= 1'b0;
      for (int i = 0; i < N_CUBES; i++) cube_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      frame_q <= frame_d;
      pulse_q <= pulse_d;
      cube_q  <= cube_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      face_l_q    <= '0;
      face_r_q    <= '0;
      face_t_q    <= '0;
      qbert_s1_q  <= 1'b0;
      qbert_s2_q  <= 1'b0;
      left_s2_q   <= 1'b0;
      right_s2_q  <= 1'b0;
      top_s2_q    <= 1'b0;
      top_st_s2_q <= '0;
      rgb_q       <= C_BLACK;
    end else begin
      face_l_q    <= left_w;
      face_r_q    <= right_w;
      face_t_q    <= top_w;
      qbert_s1_q  <= qbert_pix_i;
      qbert_s2_q  <= qbert_s1_q;
      left_s2_q   <= |face_l_q;
      right_s2_q  <= |face_r_q;
      top_s2_q    <= |face_t_q;
      top_st_s2_q <= top_st_w;
      rgb_q       <= colour_d;
    end
  end

  assign land_ready_o  = (state_q == PLAY);
  assign level_clear_o = (state_q == FLASH) || (state_q == DONE);
  assign cubes_done_o  = done_q;
  assign score_pulse_o = pulse_q;
  assign red_o         = rgb_q.r;
  assign green_o       = rgb_q.g;
  assign blue_o        = rgb_q.b;

endmodule

`default_nettype wire

// File: tb/tb_qbert_pyramid_map.sv
// Scoreboard bench for qbert_pyramid_map: stimulus queues expectations, a negedge monitor retires them.
`default_nettype none
`timescale 1ns/1ps

module tb_qbert_pyramid_map;

  typedef enum int {K_RGB, K_READY, K_DONE, K_PULSE, K_CLEAR} kind_e;
  typedef struct {
    int          due;
    kind_e       kind;
    logic [23:0] exp;
    string       name;
  } item_t;

  localparam logic [23:0] BLACK = 24'd0;
  localparam logic [23:0] TOP0  = {8'd86,  8'd70,  8'd239};
  localparam logic [23:0] TOP1  = {8'd222, 8'd222, 8'd0};
  localparam logic [23:0] LEFT  = {8'd86,  8'd169, 8'd152};
  localparam logic [23:0] RIGHT = {8'd49,  8'd70,  8'd70};
  localparam logic [23:0] QBERT = {8'd216, 8'd95,  8'd2};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] x_cnt;
  logic [9:0]  y_cnt;
  logic        qbert_pix, level_start, land_valid, land_ready;
  logic [2:0]  land_rank, land_pos;
  logic [5:0]  cubes_done;
  logic        score_pulse, level_clear;
  logic [7:0]  red, green, blue;

  item_t       sb[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          mon_i;
  logic [23:0] mon_act;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qbert_pyramid_map dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .x_cnt_i      (x_cnt),
    .y_cnt_i      (y_cnt),
    .qbert_pix_i  (qbert_pix),
    .level_start_i(level_start),
    .land_valid_i (land_valid),
    .land_ready_o (land_ready),
    .land_rank_i  (land_rank),
    .land_pos_i   (land_pos),
    .cubes_done_o (cubes_done),
    .score_pulse_o(score_pulse),
    .level_clear_o(level_clear),
    .red_o        (red),
    .green_o      (green),
    .blue_o       (blue)
  );

  function automatic logic [23:0] observe(kind_e k);
    case (k)
      K_RGB:   return {red, green, blue};
      K_READY: return {23'd0, land_ready};
      K_DONE:  return {18'd0, cubes_done};
      K_PULSE: return {23'd0, score_pulse};
      default: return {23'd0, level_clear};
    endcase
  endfunction

  always @(negedge clk) begin
    mon_i = 0;
    while (mon_i < sb.size()) begin
      if (sb[mon_i].due <= cyc) begin
        n_tests++;
        mon_act = observe(sb[mon_i].kind);
        if (sb[mon_i].due < cyc || mon_act !== sb[mon_i].exp) begin
          n_fail++;
          $display("FAIL %s: got %h, required %h (due cycle %0d, now %0d)",
                   sb[mon_i].name, mon_act, sb[mon_i].exp, sb[mon_i].due, cyc);
        end
        sb.delete(mon_i);
      end else begin
        mon_i++;
      end
    end
  end

  task automatic expect_at(input int dly, input kind_e k, input logic [23:0] e, input string nm);
    item_t it;
    it.due = cyc + dly; it.kind = k; it.exp = e; it.name = nm;
    sb.push_back(it);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input bit q, input logic [23:0] e, input string nm);
    x_cnt = 11'(x); y_cnt = 10'(y); qbert_pix = q;
    expect_at(3, K_RGB, e, nm);
    step();
    x_cnt = 11'd100; y_cnt = 10'd10; qbert_pix = 1'b0;
  endtask

  task automatic land(input int r, input int p, input bit ep, input int ed, input string nm);
    land_valid = 1'b1; land_rank = 3'(r); land_pos = 3'(p);
    expect_at(0, K_READY, 24'd1, {nm, "_ready"});
    expect_at(1, K_PULSE, {23'd0, ep}, {nm, "_pulse"});
    expect_at(1, K_DONE, 24'(ed), {nm, "_done"});
    expect_at(2, K_PULSE, 24'd0, {nm, "_pulse_end"});
    step();
    land_valid = 1'b0;
    step();
  endtask

  task automatic tick();
    x_cnt = 11'd0; y_cnt = 10'd0;
    step();
    x_cnt = 11'd100; y_cnt = 10'd10;
    step();
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
  endtask

  initial begin
    #200000;
    n_tests++; n_fail++;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    summary();
    $finish;
  end

  initial begin
    int n;
    rst_n = 1'b0; x_cnt = 11'd100; y_cnt = 10'd10; qbert_pix = 1'b0;
    level_start = 1'b0; land_valid = 1'b0; land_rank = 3'd0; land_pos = 3'd0;
    step(2);
    expect_at(0, K_RGB,   BLACK, "reset_rgb");
    expect_at(0, K_READY, 24'd0, "reset_ready");
    expect_at(0, K_DONE,  24'd0, "reset_done");
    expect_at(0, K_PULSE, 24'd0, "reset_pulse");
    expect_at(0, K_CLEAR, 24'd0, "reset_clear");
    step();
    rst_n = 1'b1;
    step(2);
    expect_at(0, K_READY, 24'd0, "idle_ready");
    step();

    level_start = 1'b1; step(); level_start = 1'b0;
    expect_at(0, K_READY, 24'd1, "play_ready");
    expect_at(0, K_CLEAR, 24'd0, "play_clear");
    step();

    pix(600, 140, 1'b0, TOP0,  "apex_top_state0");
    pix(580, 100, 1'b0, LEFT,  "apex_left");
    pix(580, 180, 1'b0, RIGHT, "apex_right");
    pix(100, 10,  1'b0, BLACK, "background");
    pix(342, 290, 1'b0, TOP0,  "r3p0_top_state0");
    pix(580, 100, 1'b1, QBERT, "qbert_over_left");
    pix(100, 10,  1'b1, QBERT, "qbert_over_black");
    step(4);

    land(0, 0, 1'b1, 1, "land_apex");
    pix(600, 140, 1'b0, TOP1, "apex_top_target");
    step(4);
    land(0, 0, 1'b0, 1, "land_apex_sat");
    land(1, 3, 1'b0, 1, "land_bad_pos");
    land(4, 0, 1'b0, 1, "land_bad_rank");

    level_start = 1'b1; land_valid = 1'b1; land_rank = 3'd1; land_pos = 3'd0;
    step();
    level_start = 1'b0; land_valid = 1'b0;
    expect_at(0, K_DONE,  24'd0, "restart_done");
    expect_at(0, K_PULSE, 24'd0, "restart_pulse");
    expect_at(0, K_READY, 24'd1, "restart_ready");
    step(3);
    pix(600, 140, 1'b0, TOP0, "restart_apex_top");
    pix(514, 190, 1'b0, TOP0, "restart_dropped_land");
    step(4);

    n = 0;
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p <= r; p++) begin
        n++;
        land(r, p, 1'b1, n, $sformatf("fill_r%0dp%0d", r, p));
      end
    end
    expect_at(0, K_CLEAR, 24'd1, "flash_clear");
    expect_at(0, K_READY, 24'd0, "flash_ready");
    step();
    pix(600, 140, 1'b0, TOP1, "flash_phase0_top");
    pix(580, 100, 1'b0, LEFT, "flash_left");
    step(4);

    repeat (8) tick();
    pix(600, 140, 1'b0, TOP0, "flash_phase1_top");
    step(4);
    repeat (55) tick();
    pix(600, 140, 1'b0, TOP0, "flash_frame63_top");
    expect_at(0, K_CLEAR, 24'd1, "flash_frame63_clear");
    step(4);
    tick();
    step(2);
    pix(600, 140, 1'b0, TOP1, "done_top");
    expect_at(0, K_CLEAR, 24'd1, "done_clear");
    expect_at(0, K_READY, 24'd0, "done_ready");
    step(4);

    level_start = 1'b1; step(); level_start = 1'b0;
    expect_at(0, K_READY, 24'd1, "replay_ready");
    expect_at(0, K_CLEAR, 24'd0, "replay_clear");
    expect_at(0, K_DONE,  24'd0, "replay_done");
    step();

    x_cnt = 11'd600; y_cnt = 10'd140;
    step(4);
    expect_at(0, K_RGB, TOP0, "pre_reset_rgb");
    step();
    #2 rst_n = 1'b0;
    expect_at(0, K_RGB,   BLACK, "async_reset_rgb");
    expect_at(0, K_READY, 24'd0, "async_reset_ready");
    step(2);

    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_drain: %0d items left, required 0", sb.size());
    end
    summary();
    $finish;
  end

endmodule

`default_nettype wire
